// File: rtl/timebase_shift_meter.sv
// Measures the cycle delay between a reference timebase sync strobe and a shifted timebase sync strobe.
// Optional feature: define SHIFT_AVERAGE_EN to report the truncated average of four measurements.
module timebase_shift_meter #(
    parameter int unsigned COUNTER_WIDTH = 16
) (
    input  logic                     clockIn,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     ref_sync,
    input  logic                     shifted_sync,
    output logic [COUNTER_WIDTH-1:0] shift_out,
    output logic                     shift_valid,
    input  logic                     shift_ready,
    output logic                     overflow
);

    localparam int unsigned          ACC_WIDTH = COUNTER_WIDTH + 2;
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = {COUNTER_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        WAIT_REF,
        COUNTING,
        REPORT
    } state_t;

    state_t                   state, state_n;
    logic [COUNTER_WIDTH-1:0] counter, counter_n;
    logic [COUNTER_WIDTH-1:0] shift_out_n;
    logic                     shift_valid_n;
    logic                     overflow_n;

    // Completed single measurement, before reporting or accumulation
    logic                     done;
    logic [COUNTER_WIDTH-1:0] meas;
    logic                     meas_ovf;

`ifdef SHIFT_AVERAGE_EN
    logic [ACC_WIDTH-1:0]     acc, acc_n;
    logic [1:0]               meas_cnt, meas_cnt_n;
    logic                     sat, sat_n;
    logic [ACC_WIDTH-1:0]     acc_sum;
`endif

    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            counter     <= '0;
            shift_out   <= '0;
            shift_valid <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state       <= state_n;
            counter     <= counter_n;
            shift_out   <= shift_out_n;
            shift_valid <= shift_valid_n;
            overflow    <= overflow_n;
        end
    end

`ifdef SHIFT_AVERAGE_EN
    always_ff @(posedge clockIn or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            meas_cnt <= '0;
            sat      <= 1'b0;
        end else begin
            acc      <= acc_n;
            meas_cnt <= meas_cnt_n;
            sat      <= sat_n;
        end
    end
`endif

    always_comb begin
        state_n       = state;
        counter_n     = counter;
        shift_out_n   = shift_out;
        shift_valid_n = shift_valid;
        overflow_n    = overflow;
        done          = 1'b0;
        meas          = '0;
        meas_ovf      = 1'b0;
`ifdef SHIFT_AVERAGE_EN
        acc_n         = acc;
        meas_cnt_n    = meas_cnt;
        sat_n         = sat;
        acc_sum       = '0;
`endif

        if (!enable) begin
            state_n       = IDLE;
            counter_n     = '0;
            shift_valid_n = 1'b0;
`ifdef SHIFT_AVERAGE_EN
            acc_n         = '0;
            meas_cnt_n    = '0;
            sat_n         = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: state_n = WAIT_REF;
                WAIT_REF: begin
                    if (ref_sync && shifted_sync) begin
                        done = 1'b1;
                    end else if (ref_sync) begin
                        counter_n = COUNTER_WIDTH'(1);
                        state_n   = COUNTING;
                    end
                end
                COUNTING: begin
                    // A shifted strobe wins over a simultaneous reference restart
                    if (shifted_sync) begin
                        done = 1'b1;
                        meas = counter;
                    end else if (ref_sync) begin
                        counter_n = COUNTER_WIDTH'(1);
                    end else if (counter == CNT_MAX) begin
                        done     = 1'b1;
                        meas     = CNT_MAX;
                        meas_ovf = 1'b1;
                    end else begin
                        counter_n = counter + COUNTER_WIDTH'(1);
                    end
                end
                REPORT: begin
                    if (shift_valid && shift_ready) begin
                        state_n       = WAIT_REF;
                        shift_valid_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase

            if (done) begin
                counter_n = '0;
`ifdef SHIFT_AVERAGE_EN
                acc_sum = acc + ACC_WIDTH'(meas);
                if (meas_cnt == 2'd3) begin
                    shift_out_n   = (sat || meas_ovf) ? CNT_MAX : COUNTER_WIDTH'(acc_sum >> 2);
                    overflow_n    = sat || meas_ovf;
                    shift_valid_n = 1'b1;
                    state_n       = REPORT;
                    acc_n         = '0;
                    meas_cnt_n    = '0;
                    sat_n         = 1'b0;
                end else begin
                    acc_n      = acc_sum;
                    meas_cnt_n = meas_cnt + 2'd1;
                    sat_n      = sat || meas_ovf;
                    state_n    = WAIT_REF;
                end
`else
                shift_out_n   = meas;
                overflow_n    = meas_ovf;
                shift_valid_n = 1'b1;
                state_n       = REPORT;
`endif
            end
        end
    end

endmodule

// File: tb/tb_timebase_shift_meter.sv
// Directed bench for timebase_shift_meter: scoreboard of expected results plus point checks.
module tb_timebase_shift_meter;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        ref_sync;
    logic        shifted_sync;
    logic        shift_ready;
    logic [15:0] shift_out;
    logic        shift_valid;
    logic        overflow;
    logic [3:0]  shift_out4;
    logic        shift_valid4;
    logic        overflow4;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [16:0] exp_q[$];

    timebase_shift_meter #(.COUNTER_WIDTH(16)) dut (
        .clockIn      (clk),
        .reset        (rst_n),
        .enable       (enable),
        .ref_sync     (ref_sync),
        .shifted_sync (shifted_sync),
        .shift_out    (shift_out),
        .shift_valid  (shift_valid),
        .shift_ready  (shift_ready),
        .overflow     (overflow)
    );

    timebase_shift_meter #(.COUNTER_WIDTH(4)) dut4 (
        .clockIn      (clk),
        .reset        (rst_n),
        .enable       (enable),
        .ref_sync     (ref_sync),
        .shifted_sync (shifted_sync),
        .shift_out    (shift_out4),
        .shift_valid  (shift_valid4),
        .shift_ready  (shift_ready),
        .overflow     (overflow4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic r, input logic s);
        ref_sync     = r;
        shifted_sync = s;
        step();
        ref_sync     = 1'b0;
        shifted_sync = 1'b0;
    endtask

    task automatic push(input logic [15:0] v, input logic o);
        exp_q.push_back({o, v});
    endtask

    // Scoreboard: every accepted result must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n && shift_valid && shift_ready) begin
            logic [16:0] e;
            if (exp_q.size() == 0) begin
                chk("unexpected_result", {15'd0, overflow, shift_out}, 32'h1ffff);
            end else begin
                e = exp_q.pop_front();
                chk("sb_shift_out", 32'(shift_out), 32'(e[15:0]));
                chk("sb_overflow", 32'(overflow), 32'(e[16]));
            end
        end
    end

    initial begin
        int meas_k[4];
        meas_k = '{10, 11, 12, 14};
        rst_n        = 1'b0;
        enable       = 1'b0;
        ref_sync     = 1'b0;
        shifted_sync = 1'b0;
        shift_ready  = 1'b0;

        #2;
        chk("rst_shift_out", 32'(shift_out), 32'd0);
        chk("rst_valid", 32'(shift_valid), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        #10;
        rst_n       = 1'b1;
        enable      = 1'b1;
        shift_ready = 1'b1;
        step();
        step();

        // Basic: ref at edge N, shifted at N+25
        pulse(1'b1, 1'b0);
        repeat (24) step();
        push(16'd25, 1'b0);
        pulse(1'b0, 1'b1);
        chk("basic_valid", 32'(shift_valid), 32'd1);
        chk("basic_value", 32'(shift_out), 32'd25);
        step();
        chk("basic_valid_one_cycle", 32'(shift_valid), 32'd0);

        // Simultaneous strobes, result held while not ready
        shift_ready = 1'b0;
        push(16'd0, 1'b0);
        pulse(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("held_valid", 32'(shift_valid), 32'd1);
            chk("held_value", 32'(shift_out), 32'd0);
            pulse(i[0], 1'b1);
        end
        shift_ready = 1'b1;
        step();
        chk("held_released", 32'(shift_valid), 32'd0);

        // Shifted alone ignored, then restart by a later reference
        pulse(1'b0, 1'b1);
        chk("lone_shifted_ignored", 32'(shift_valid), 32'd0);
        pulse(1'b1, 1'b0);
        repeat (6) step();
        pulse(1'b1, 1'b0);
        repeat (2) step();
        push(16'd3, 1'b0);
        pulse(1'b0, 1'b1);
        chk("restart_valid", 32'(shift_valid), 32'd1);
        chk("restart_value", 32'(shift_out), 32'd3);
        step();

        // Four individual measurements
        foreach (meas_k[i]) begin
            pulse(1'b1, 1'b0);
            repeat (meas_k[i] - 1) step();
            push(16'(meas_k[i]), 1'b0);
            pulse(1'b0, 1'b1);
            step();
        end

        // Saturation on the 4-bit instance
        enable = 1'b0;
        step();
        enable      = 1'b1;
        shift_ready = 1'b0;
        step();
        step();
        pulse(1'b1, 1'b0);
        repeat (14) step();
        chk("sat_not_yet", 32'(shift_valid4), 32'd0);
        step();
        chk("sat_valid", 32'(shift_valid4), 32'd1);
        chk("sat_value", 32'(shift_out4), 32'hf);
        chk("sat_overflow", 32'(overflow4), 32'd1);

        // Enable drop while the wide instance is still counting
        chk("counting_no_valid", 32'(shift_valid), 32'd0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("disable_valid", 32'(shift_valid), 32'd0);
            chk("disable_valid4", 32'(shift_valid4), 32'd0);
        end
        enable = 1'b1;
        step();
        step();

        // Asynchronous reset between edges while in REPORT
        pulse(1'b1, 1'b0);
        repeat (3) step();
        pulse(1'b0, 1'b1);
        chk("pre_reset_valid", 32'(shift_valid), 32'd1);
        chk("pre_reset_value", 32'(shift_out), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_value", 32'(shift_out), 32'd0);
        chk("async_rst_valid", 32'(shift_valid), 32'd0);
        chk("async_rst_overflow", 32'(overflow), 32'd0);
        chk("async_rst_valid4", 32'(shift_valid4), 32'd0);
        #2;
        rst_n = 1'b1;
        step();

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timebase_shift_meter.md
# timebase_shift_meter

Measures the phase shift, in clock cycles, between a reference timebase sync pulse and the sync pulse of a delayed (shifted) timebase in the PWM generator. It is the read-back counterpart of the timebase shifter: the shifter applies a programmed delay, and this block measures the delay actually produced. The result goes to the control/monitor logic over a valid/ready handshake. It sits beside the PWM generator chain, observing the sync strobes of the master and each shifted counter.

## Interface
- COUNTER_WIDTH, 16, width of the measured shift and of the internal counter.
- clockIn  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  measurement enable; low forces IDLE.
- ref_sync  input  1  single-cycle strobe from the reference timebase (counter reload).
- shifted_sync  input  1  single-cycle strobe from the shifted timebase.
- shift_out  output  COUNTER_WIDTH  measured shift in clock cycles.
- shift_valid  output  1  shift_out/overflow valid; held until accepted.
- shift_ready  input  1  consumer accepts the result when high with shift_valid.
- overflow  output  1  qualifies shift_out: no shifted_sync before the counter saturated.

## Operation
- Reset values: shift_out = 0, shift_valid = 0, overflow = 0, counter = 0, state = IDLE.
- States: IDLE, WAIT_REF, COUNTING, REPORT.
- IDLE: enable high -> WAIT_REF on the next edge.
- WAIT_REF:
  - shifted_sync alone is ignored.
  - ref_sync alone -> counter <= 1, go to COUNTING.
  - ref_sync and shifted_sync in the same cycle -> shift_out <= 0, overflow <= 0, go to REPORT.
- COUNTING:
  - shifted_sync -> shift_out <= counter, overflow <= 0, go to REPORT. This applies even if ref_sync is high in the same cycle.
  - ref_sync without shifted_sync -> counter <= 1. Restart: the latest reference wins.
  - Neither strobe: counter <= counter + 1.
  - Counter equal to all ones with no shifted_sync -> shift_out <= all ones, overflow <= 1, go to REPORT. The counter never wraps.
- REPORT: shift_valid = 1; shift_out and overflow are stable.
  - Both strobes are ignored; events during REPORT are lost.
  - shift_valid and shift_ready both high -> WAIT_REF on that edge, so ref_sync in that same cycle is not captured.
- enable low in any state -> IDLE on the next edge; shift_valid drops, a pending result is discarded, and the counter clears.
- Arithmetic is unsigned. The result is the number of rising edges from the sampled ref_sync to the sampled shifted_sync.

## Timing
- ref_sync sampled at edge N and shifted_sync at edge N+k (1 ≤ k ≤ 2^W-2): shift_out = k and shift_valid are visible after edge N+k. This is 0 cycles of added latency beyond the sampling edge.
- Saturation: with no shifted_sync, REPORT with overflow is entered at edge N + 2^W - 1.
- Back-to-back: a result accepted at edge M lets the next ref_sync be captured at edge M+1 at the earliest.
- Reset asserted mid-measurement clears all outputs immediately, without waiting for a clock edge.

## Configuration
- SHIFT_AVERAGE_EN defined:
  - Four consecutive measurements are accumulated in a COUNTER_WIDTH+2 bit accumulator.
  - The block returns to WAIT_REF internally after each measurement, without asserting shift_valid.
  - After the 4th measurement, shift_valid asserts with shift_out = accumulator >> 2 (truncating).
  - If any of the four saturates, the result is all ones with overflow = 1.
  - enable low or reset clears the accumulator and the measurement count.
- SHIFT_AVERAGE_EN undefined: every measurement is reported individually, as described in Operation. No accumulator is synthesized.

## Test plan
- Basic measurement: reset released, enable = 1, shift_ready = 1, ref_sync at cycle 10, shifted_sync at cycle 35 -> shift_out = 25, overflow = 0, shift_valid high for exactly one cycle.
- Simultaneous strobes and held result: ref_sync and shifted_sync together in WAIT_REF, shift_ready held low for 5 cycles -> shift_out = 0 and shift_valid held for all 5 cycles. Extra strobes during that time change nothing. Accept -> WAIT_REF.
- Saturation: COUNTER_WIDTH = 4, ref_sync only -> after 15 cycles shift_out = 4'hF, overflow = 1, shift_valid = 1.
- Restart: ref_sync at cycle 0, ref_sync again at cycle 7, shifted_sync at cycle 10 -> shift_out = 3.
- Mid-operation disruption: enable dropped in COUNTING -> shift_valid stays 0. Asynchronous reset pulse between clock edges during REPORT -> all outputs 0 immediately.
- Averaging (SHIFT_AVERAGE_EN): four measurements of 10, 11, 12, 14 -> a single shift_valid with shift_out = 11. Without the macro -> four results 10, 11, 12, 14.
